// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default sample width, channel encoding on ws, receiver states.
package i2s_pkg;

    localparam int unsigned DEFAULT_BITS_PRECISION = 24;

    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        SYNC,
        RECV_L,
        RECV_R
    } rx_state_t;

endpackage

// File: rtl/i2s_word_deser.sv
// MSB-first word deserialiser: gated shift register, saturating bit count, left-align of the
// word finalised in the current cycle (the current sd bit included).
module i2s_word_deser
    import i2s_pkg::*;
#(
    parameter int unsigned BITS_PRECISION = DEFAULT_BITS_PRECISION
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      shift_en,
    input  logic                      sd,
    output logic [BITS_PRECISION-1:0] word,
    output logic                      len_ok
);

    localparam int unsigned CNT_W = $clog2(BITS_PRECISION + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BITS_PRECISION);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(BITS_PRECISION + 1);

    logic [BITS_PRECISION-1:0] shreg, shreg_nx;
    logic [CNT_W-1:0]          cnt, cnt_nx, n_bits;

    // Bits past the word width are dropped; the count keeps going to flag over-length.
    always_comb begin
        shreg_nx = shreg;
        if (cnt < CNT_FULL) begin
            shreg_nx = {shreg[BITS_PRECISION-2:0], sd};
        end
        cnt_nx = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
        n_bits = (cnt_nx > CNT_FULL) ? CNT_FULL : cnt_nx;
        word   = shreg_nx << (CNT_FULL - n_bits);
        len_ok = (cnt_nx == CNT_FULL);
    end

    always_ff @(posedge sck) begin
        if (rst || clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= shreg_nx;
            cnt   <= cnt_nx;
        end
    end

endmodule

// File: rtl/i2sin.sv
// I2S (Philips) receiver: deserialises ws/sd into left/right samples, pulses data_valid per frame.
// Define I2SIN_LEN_CHECK_EN to add the frame_err output flagging words of the wrong length.
module i2sin
    import i2s_pkg::*;
#(
    parameter int unsigned BITS_PRECISION = DEFAULT_BITS_PRECISION
) (
    input  logic                      sck,
    input  logic                      rst,
    input  logic                      ws,
    input  logic                      sd,
    output logic [BITS_PRECISION-1:0] l_data,
    output logic [BITS_PRECISION-1:0] r_data,
    output logic                      data_valid
`ifdef I2SIN_LEN_CHECK_EN
    ,
    output logic                      frame_err
`endif
);

    rx_state_t                 state;
    logic                      ws_d;
    logic                      fall, rise;
    logic                      clear, shift_en;
    logic [BITS_PRECISION-1:0] word;
    logic                      len_ok;
    logic [BITS_PRECISION-1:0] l_hold;

    assign fall     = (ws_d == WS_RIGHT) && (ws == WS_LEFT);
    assign rise     = (ws_d == WS_LEFT) && (ws == WS_RIGHT);
    assign shift_en = (state != SYNC);

    // Every accepted edge closes the current word; in SYNC the edge-cycle bit is just dropped.
    always_comb begin
        clear = 1'b0;
        unique case (state)
            SYNC:    clear = fall;
            RECV_L:  clear = rise;
            RECV_R:  clear = fall;
            default: clear = 1'b0;
        endcase
    end

    i2s_word_deser #(
        .BITS_PRECISION(BITS_PRECISION)
    ) u_deser (
        .sck      (sck),
        .rst      (rst),
        .clear    (clear),
        .shift_en (shift_en),
        .sd       (sd),
        .word     (word),
        .len_ok   (len_ok)
    );

`ifdef I2SIN_LEN_CHECK_EN
    logic l_ok;
`else
    logic unused_len_ok;
    assign unused_len_ok = len_ok;
`endif

    always_ff @(posedge sck) begin
        if (rst) begin
            state      <= SYNC;
            ws_d       <= 1'b0;
            l_hold     <= '0;
            l_data     <= '0;
            r_data     <= '0;
            data_valid <= 1'b0;
`ifdef I2SIN_LEN_CHECK_EN
            l_ok       <= 1'b0;
            frame_err  <= 1'b0;
`endif
        end else begin
            ws_d       <= ws;
            data_valid <= 1'b0;
`ifdef I2SIN_LEN_CHECK_EN
            frame_err  <= 1'b0;
`endif
            case (state)
                SYNC: begin
                    if (fall) state <= RECV_L;
                end
                RECV_L: begin
                    if (rise) begin
                        l_hold <= word;
`ifdef I2SIN_LEN_CHECK_EN
                        l_ok   <= len_ok;
`endif
                        state  <= RECV_R;
                    end
                end
                RECV_R: begin
                    if (fall) begin
                        l_data     <= l_hold;
                        r_data     <= word;
                        data_valid <= 1'b1;
`ifdef I2SIN_LEN_CHECK_EN
                        frame_err  <= !(l_ok && len_ok);
`endif
                        state      <= RECV_L;
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_i2sin.sv
// Scoreboard bench for i2sin: stimulus pushes expected frames, a negedge monitor checks each pulse.
module tb_i2sin;
    import i2s_pkg::*;

    localparam int unsigned BP = 24;

    logic          sck = 1'b0;
    logic          rst = 1'b1;
    logic          ws  = 1'b0;
    logic          sd  = 1'b0;
    logic [BP-1:0] l_data, r_data;
    logic          data_valid;
`ifdef I2SIN_LEN_CHECK_EN
    logic          frame_err;
`endif

    i2sin #(
        .BITS_PRECISION(BP)
    ) dut (
        .sck        (sck),
        .rst        (rst),
        .ws         (ws),
        .sd         (sd),
        .l_data     (l_data),
        .r_data     (r_data),
        .data_valid (data_valid)
`ifdef I2SIN_LEN_CHECK_EN
        ,
        .frame_err  (frame_err)
`endif
    );

    always #5 sck = ~sck;

    typedef struct {
        logic [BP-1:0] l;
        logic [BP-1:0] r;
        logic          err;
        int unsigned   cyc;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    always @(posedge sck) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every data_valid pulse must match the head of the scoreboard, on the exact cycle.
    always @(negedge sck) begin
        if (!rst && data_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: data_valid high with nothing expected (cycle %0d)",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("l_data", 32'(l_data), 32'(e.l));
                check("r_data", 32'(r_data), 32'(e.r));
                check("pulse_cycle", cyc, e.cyc);
`ifdef I2SIN_LEN_CHECK_EN
                check("frame_err", 32'(frame_err), 32'(e.err));
`endif
            end
        end
    end

    task automatic drive(input logic w, input logic s);
        @(negedge sck);
        ws = w;
        sd = s;
    endtask

    task automatic do_reset();
        @(negedge sck);
        rst = 1'b1;
        repeat (2) @(negedge sck);
        rst = 1'b0;
    endtask

    // ws=1 then a falling edge; the edge-cycle bit is discarded in SYNC.
    task automatic sync_start();
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    // Philips timing: ws flips together with the word's LSB.
    task automatic send_word(input logic ch, input logic [63:0] val, input int n);
        for (int k = 0; k < n; k++) begin
            drive((k == n - 1) ? ~ch : ch, val[n-1-k]);
        end
    endtask

    task automatic send_frame(input logic [63:0] l, input int lb, input logic [63:0] r,
                              input int rb, input logic [BP-1:0] exp_l,
                              input logic [BP-1:0] exp_r, input logic exp_err);
        exp_t e;
        send_word(WS_LEFT, l, lb);
        send_word(WS_RIGHT, r, rb);
        e.l   = exp_l;
        e.r   = exp_r;
        e.err = exp_err;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    initial begin
        // Reset state, then ws stuck low: no pulse, outputs stay zero.
        do_reset();
        check("reset_l_data", 32'(l_data), 32'h0);
        check("reset_r_data", 32'(r_data), 32'h0);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        repeat (100) drive(1'b0, 1'b1);
        check("idle_l_data", 32'(l_data), 32'h0);
        check("idle_r_data", 32'(r_data), 32'h0);

        // Single nominal frame.
        do_reset();
        sync_start();
        send_frame(64'hA5F00F, 24, 64'h5A0FF0, 24, 24'hA5F00F, 24'h5A0FF0, 1'b0);
        repeat (4) drive(1'b0, 1'b0);

        // Three back-to-back frames, pulses 48 cycles apart.
        do_reset();
        sync_start();
        for (int i = 0; i < 3; i++) begin
            send_frame(64'(2 * i + 1), 24, 64'(2 * i + 2), 24, BP'(2 * i + 1), BP'(2 * i + 2),
                       1'b0);
        end
        repeat (4) drive(1'b0, 1'b0);

        // Short words are zero-padded.
        do_reset();
        sync_start();
        send_frame(64'hBEEF, 16, 64'h1234, 16, 24'hBEEF00, 24'h123400, 1'b1);
        repeat (4) drive(1'b0, 1'b0);

        // Long words are truncated, then minimum one-bit words.
        do_reset();
        sync_start();
        send_frame(64'h12345678, 32, 64'h9ABCDEF0, 32, 24'h123456, 24'h9ABCDE, 1'b1);
        send_frame(64'h1, 1, 64'h0, 1, 24'h800000, 24'h000000, 1'b1);
        repeat (4) drive(1'b0, 1'b0);
        check("hold_l_data", 32'(l_data), 32'h800000);

        // Reset mid right word clears outputs; the torn frame is never reported.
        do_reset();
        sync_start();
        send_frame(64'h654321, 24, 64'hABCDEF, 24, 24'h654321, 24'hABCDEF, 1'b0);
        send_word(WS_LEFT, 64'h111111, 24);
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1);
        @(negedge sck);
        rst = 1'b1;
        repeat (2) @(negedge sck);
        rst = 1'b0;
        check("midreset_l_data", 32'(l_data), 32'h0);
        check("midreset_r_data", 32'(r_data), 32'h0);
        for (int k = 0; k < 14; k++) drive((k == 13) ? 1'b0 : 1'b1, 1'b1);
        send_frame(64'h0F0F0F, 24, 64'hF0F0F0, 24, 24'h0F0F0F, 24'hF0F0F0, 1'b0);
        repeat (4) drive(1'b0, 1'b0);

        // Reset mid left word: the remainder of that left word and its right are ignored.
        do_reset();
        sync_start();
        for (int k = 0; k < 10; k++) drive(1'b0, 1'b1);
        do_reset();
        for (int k = 0; k < 14; k++) drive((k == 13) ? 1'b1 : 1'b0, 1'b1);
        send_word(WS_RIGHT, 64'h777777, 24);
        send_frame(64'hC0FFEE, 24, 64'h0BADF0, 24, 24'hC0FFEE, 24'h0BADF0, 1'b0);
        repeat (5) drive(1'b0, 1'b0);

        check("pending_frames", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2sin.md
Name: i2sin

Overview:
- I2S receiver: deserialises an external ADC/codec I2S stream (ws, sd) into parallel left/right samples for the mixer datapath.
- Runs in the same sck domain as the I2S transmitter stage, so it needs no CDC.
- Outputs hold the last complete stereo frame and pulse data_valid once per frame.
- The mixer core, or the transmitter's l_data/r_data/data_en inputs, consume that frame directly.

Parameters:
- BITS_PRECISION, 24, sample width in bits, MSB-first on the wire.

Ports:
- sck  input  1  I2S bit clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- ws  input  1  word select: 0 = left channel, 1 = right channel.
- sd  input  1  serial data.
- l_data  output  BITS_PRECISION  last complete left sample, left-aligned.
- r_data  output  BITS_PRECISION  last complete right sample, left-aligned.
- data_valid  output  1  one-cycle pulse when l_data/r_data update.
- frame_err  output  1  present only with I2SIN_LEN_CHECK_EN; see Optional Feature.

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - l_data=0, r_data=0, data_valid=0, frame_err=0.
  - ws_d=0, shift register and bit counter cleared, state=SYNC.
  - Any partial frame is discarded.
- Sampling and edge detection:
  - ws and sd sampled every posedge; ws_d holds the previous ws.
  - Falling edge = ws_d=1 & ws=0. Rising edge = ws_d=0 & ws=1.
- Philips timing:
  - The sd bit sampled at the posedge where a ws edge is detected is the LSB of the word just ending.
  - The MSB of the new word is the next sample.
- States: SYNC, RECV_L, RECV_R.
- SYNC:
  - Ignore sd and rising edges.
  - On a falling edge: clear shreg and cnt, go to RECV_L. The edge-cycle sd is discarded.
- RECV_L / RECV_R, no edge:
  - If cnt<BITS_PRECISION, shreg <= {shreg[MSB-1:0], sd}.
  - cnt increments and saturates at BITS_PRECISION+1.
- RECV_L, rising edge:
  - Include the edge-cycle sd as the final bit (same rule as above).
  - word = shreg left-aligned: shift left by BITS_PRECISION-n, where n = number of bits stored (≤BITS_PRECISION).
  - Store word in l_hold, clear shreg/cnt, go to RECV_R.
- RECV_R, falling edge:
  - Finalise the right word the same way.
  - At that same posedge: l_data<=l_hold, r_data<=word, data_valid<=1.
  - Clear shreg/cnt, go to RECV_L.
- Latency: data_valid is high for exactly the one cycle following the posedge at which the falling edge was sampled.
- data_valid is 0 in every other cycle. Outputs hold between frames.
- Short word (n<BITS_PRECISION): zero-pad LSBs.
- Long word: extra LSBs are dropped (truncation, not rounding).
- Wrong-direction edge cannot occur, because ws is binary. A ws stuck level means no data_valid, and outputs hold their values.
- Minimum word: 1 bit, when ws toggles on consecutive posedges.
- The first data_valid after reset requires one full L and one full R word after the first falling edge.

Optional Feature:
- Macro: I2SIN_LEN_CHECK_EN.
- With the macro:
  - frame_err port exists; it asserts together with data_valid (same cycle, one pulse) if either word of the frame had n≠BITS_PRECISION.
  - Over-length counts use the saturated cnt value BITS_PRECISION+1.
  - Data is still delivered, padded or truncated as above.
- Without the macro:
  - No frame_err port and no length tracking beyond the shift gate.
  - Malformed words are delivered silently.

Decomposition:
- Package i2s_pkg:
  - DEFAULT_BITS_PRECISION=24.
  - typedef enum for rx state {SYNC, RECV_L, RECV_R}.
  - Channel constants WS_LEFT=0, WS_RIGHT=1 (shared with the transmitter).
- One sub-module, i2s_word_deser:
  - Contains shreg, the saturating cnt, and the left-align shift.
  - Has clear/shift-enable inputs and outputs word and len_ok.
  - Instantiated once; the top holds the FSM, l_hold, and the output registers.

Test Plan:
- Reset, then ws held 0 for 100 cycles -> data_valid never asserts, l_data=r_data=0.
- Frame L=0xA5F00F, R=0x5A0FF0, 24 bits each, MSB one cycle after each ws edge -> single data_valid pulse one cycle after the ws falling edge, l_data=0xA5F00F, r_data=0x5A0FF0, frame_err=0.
- Three back-to-back frames with incrementing samples 0x000001..0x000006 -> three pulses exactly 48 cycles apart, each pair correct, no lost or merged frames.
- 16-bit words L=0xBEEF, R=0x1234 at BITS_PRECISION=24 -> l_data=0xBEEF00, r_data=0x123400, frame_err=1 (LEN_CHECK build).
- 32-bit words L=0x12345678, R=0x9ABCDEF0 -> l_data=0x123456, r_data=0x9ABCDE, frame_err=1.
- rst asserted mid right word, then deasserted -> outputs zero; first pulse only after the next complete L+R pair; a partial L word already in progress is not reported.
